// File: rtl/spi_master_engine.sv
// SPI master datapath: baud generator, slave-select framing and 8-bit TX/RX shifting.
// Define SPI_LOOPBACK_EN to feed mosi back as the serial input (the miso port is then ignored).
module spi_master_engine (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        send_data,
    input  logic [7:0]  data_mosi,
    input  logic        miso,
    input  logic [1:0]  spi_mode,
    input  logic        spiswai,
    input  logic        mstr,
    input  logic        cpol,
    input  logic        cpha,
    input  logic        lsbfe,
    input  logic [2:0]  spr,
    input  logic [2:0]  sppr,
    output logic        sclk,
    output logic        ss,
    output logic        mosi,
    output logic        tip,
    output logic        receive_data,
    output logic [7:0]  data_miso,
    output logic [11:0] baud_rate_div
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIV_W  = 12;
    localparam int unsigned HALF_W = 11;
    localparam int unsigned EDGE_W = 5;

    localparam logic [1:0]        MODE_RUN  = 2'b00;
    localparam logic [1:0]        MODE_WAIT = 2'b01;
    localparam logic [EDGE_W-1:0] LAST_EDGE = 5'd16;

    logic              ss_q, ss_d;
    logic              tip_q, tip_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              rx_done_q, rx_done_d;
    logic [DATA_W-1:0] data_miso_q, data_miso_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [HALF_W-1:0] cnt_q, cnt_d;
    logic [EDGE_W-1:0] edge_q, edge_d;

    logic              enabled_c;
    logic              start_c;
    logic              tick_c;
    logic              drive_c;
    logic              sample_c;
    logic              serial_in_c;
    logic [HALF_W-1:0] half_c;
    logic [EDGE_W-1:0] edge_num_c;
    logic [2:0]        drv_bit_c;
    logic [DATA_W-1:0] rx_shift_c;

    // Divisor = (sppr+1) * 2^(spr+1); half period = (sppr+1) * 2^spr, max 1024.
    assign baud_rate_div = DIV_W'({1'b0, sppr} + 4'd1) << ({1'b0, spr} + 4'd1);
    assign half_c        = HALF_W'({1'b0, sppr} + 4'd1) << spr;

    assign enabled_c = mstr & ((spi_mode == MODE_RUN) | ((spi_mode == MODE_WAIT) & ~spiswai));
    assign start_c   = send_data & enabled_c;

`ifdef SPI_LOOPBACK_EN
    assign serial_in_c = mosi_q;
`else
    assign serial_in_c = miso;
`endif

    // Edge bookkeeping: edge_num_c is the sclk edge taken on this tick (1..16).
    assign tick_c     = (cnt_q == (half_c - HALF_W'(1)));
    assign edge_num_c = edge_q + EDGE_W'(1);
    assign drv_bit_c  = edge_num_c[3:1];
    assign drive_c    = (edge_num_c[0] == cpha) && (edge_num_c != LAST_EDGE);
    assign sample_c   = (edge_num_c[0] != cpha);
    assign rx_shift_c = lsbfe ? {serial_in_c, rx_q[DATA_W-1:1]}
                              : {rx_q[DATA_W-2:0], serial_in_c};

    // Next-state logic for framing, baud counter and data path.
    always_comb begin
        ss_d        = ss_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        rx_done_d   = 1'b0;
        data_miso_d = data_miso_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        cnt_d       = cnt_q;
        edge_d      = edge_q;

        if (ss_q) begin
            sclk_d = cpol;
            cnt_d  = '0;
            edge_d = '0;
            if (start_c) begin
                ss_d   = 1'b0;
                tx_d   = data_mosi;
                rx_d   = '0;
                mosi_d = lsbfe ? data_mosi[0] : data_mosi[DATA_W-1];
            end
        end else if (!enabled_c) begin
            // Abort: drop the frame without touching data_miso.
            ss_d   = 1'b1;
            sclk_d = cpol;
            cnt_d  = '0;
            edge_d = '0;
        end else if (tick_c) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
            edge_d = edge_num_c;
            if (drive_c) begin
                mosi_d = lsbfe ? tx_q[drv_bit_c] : tx_q[3'd7 - drv_bit_c];
            end
            if (sample_c) begin
                rx_d = rx_shift_c;
            end
            if (edge_num_c == LAST_EDGE) begin
                ss_d        = 1'b1;
                sclk_d      = cpol;
                edge_d      = '0;
                rx_done_d   = 1'b1;
                data_miso_d = rx_d;
            end
        end else begin
            cnt_d = cnt_q + HALF_W'(1);
        end

        tip_d = ~ss_d;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ss_q        <= 1'b1;
            tip_q       <= 1'b0;
            sclk_q      <= cpol;
            mosi_q      <= 1'b0;
            rx_done_q   <= 1'b0;
            data_miso_q <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            cnt_q       <= '0;
            edge_q      <= '0;
        end else begin
            ss_q        <= ss_d;
            tip_q       <= tip_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            rx_done_q   <= rx_done_d;
            data_miso_q <= data_miso_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cnt_q       <= cnt_d;
            edge_q      <= edge_d;
        end
    end

    assign ss           = ss_q;
    assign tip          = tip_q;
    assign sclk         = sclk_q;
    assign mosi         = mosi_q;
    assign receive_data = rx_done_q;
    assign data_miso    = data_miso_q;

endmodule

// File: tb/tb_spi_master_engine.sv
// Bench for spi_master_engine: cycle model of the SPI frame plus directed transfers.
module tb_spi_master_engine;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        send_data;
    logic [7:0]  data_mosi;
    logic        miso_w;
    logic [1:0]  spi_mode;
    logic        spiswai, mstr, cpol, cpha, lsbfe;
    logic [2:0]  spr, sppr;
    logic        sclk, ss, mosi, tip, receive_data;
    logic [7:0]  data_miso;
    logic [11:0] baud_rate_div;

    logic miso_val, loop_sel;
    assign miso_w = loop_sel ? mosi : miso_val;

    always #5 PCLK = ~PCLK;

    spi_master_engine dut (
        .PCLK(PCLK), .PRESET(PRESET), .send_data(send_data), .data_mosi(data_mosi),
        .miso(miso_w), .spi_mode(spi_mode), .spiswai(spiswai), .mstr(mstr),
        .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe), .spr(spr), .sppr(sppr),
        .sclk(sclk), .ss(ss), .mosi(mosi), .tip(tip), .receive_data(receive_data),
        .data_miso(data_miso), .baud_rate_div(baud_rate_div)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bdiv(input logic [2:0] pp, input logic [2:0] rr);
        return (int'(pp) + 1) * (2 ** (int'(rr) + 1));
    endfunction

    // Reference model: position n within a frame determines every output.
    logic       chk_on = 1'b0;
    logic       m_active = 1'b0, m_mosi_chk = 1'b0;
    int         m_n = 0, m_br = 2, m_half = 1;
    logic       m_cpol = 1'b0, m_cpha = 1'b0, m_lsbfe = 1'b0;
    logic [7:0] m_tx = 8'h00, m_rx = 8'h00;
    logic       e_ss = 1'b1, e_tip = 1'b0, e_sclk = 1'b0, e_mosi = 1'b0, e_rd = 1'b0;
    logic [7:0] e_dm = 8'h00;

    task automatic model_step();
        logic en;
        int   k, b;
        en   = mstr && ((spi_mode == 2'b00) || ((spi_mode == 2'b01) && !spiswai));
        e_rd = 1'b0;
        if (PRESET) begin
            m_active = 1'b0; e_ss = 1'b1; e_sclk = cpol; e_mosi = 1'b0; e_dm = 8'h00;
            m_mosi_chk = 1'b1; chk_on = 1'b1;
        end else if (m_active && !en) begin
            m_active = 1'b0; e_ss = 1'b1; e_sclk = cpol; m_mosi_chk = 1'b0;
        end else if (m_active) begin
            m_n++;
            if (m_n == 8 * m_br) begin
                m_active = 1'b0; e_ss = 1'b1; e_sclk = m_cpol; e_rd = 1'b1; e_dm = m_rx;
                m_mosi_chk = 1'b0;
            end else begin
                k      = m_n / m_half;
                e_sclk = m_cpol ^ k[0];
                b      = m_cpha ? ((k - 1) / 2) : (k / 2);
                e_mosi = m_lsbfe ? m_tx[b] : m_tx[7-b];
                m_mosi_chk = !(m_cpha && (k == 0));
            end
        end else begin
            e_sclk = cpol;
            if (send_data && en) begin
                m_active = 1'b1; m_n = 0; m_br = bdiv(sppr, spr); m_half = m_br / 2;
                m_cpol = cpol; m_cpha = cpha; m_lsbfe = lsbfe; m_tx = data_mosi;
                m_rx   = loop_sel ? data_mosi : {8{miso_val}};
                e_ss   = 1'b0;
                e_mosi = lsbfe ? data_mosi[0] : data_mosi[7];
                m_mosi_chk = !cpha;
            end
        end
        e_tip = !e_ss;
    endtask

    initial forever begin
        @(posedge PCLK);
        model_step();
    end

    // Single compare process, away from the active edge.
    initial forever begin
        @(negedge PCLK);
        if (chk_on) begin
            check("ss", 12'(ss), 12'(e_ss));
            check("tip", 12'(tip), 12'(e_tip));
            check("sclk", 12'(sclk), 12'(e_sclk));
            check("receive_data", 12'(receive_data), 12'(e_rd));
            check("data_miso", 12'(data_miso), 12'(e_dm));
            if (m_mosi_chk) check("mosi", 12'(mosi), 12'(e_mosi));
        end
    end

    task automatic start_xfer(input logic [7:0] d);
        send_data = 1'b1;
        data_mosi = d;
        @(negedge PCLK);
        send_data = 1'b0;
    endtask

    // Observe one frame from the cycle after the start edge; bounded.
    task automatic run_frame(input int half, input logic ph, output logic [7:0] cap,
                             output int low, output int rdp, output int per);
        int   t1, t3, tog;
        logic prev;
        bit   done;
        cap = 8'h00; low = 0; rdp = 0; tog = 0; t1 = 0; t3 = 0; prev = sclk; done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            if (sclk !== prev) begin
                tog++;
                if (tog == 1) t1 = i;
                if (tog == 3) t3 = i;
            end
            prev = sclk;
            if (ss === 1'b0) low++;
            if (receive_data === 1'b1) rdp++;
            for (int b = 0; b < 8; b++)
                if (i == (2 * b + 1 + int'(ph)) * half - 1) cap[b] = mosi;
            if (ss === 1'b1) done = 1'b1;
            @(negedge PCLK);
        end
        if (!done) begin
            n_checks++;
            n_fails++;
            $display("FAIL frame_timeout: ss still low after 20000 cycles");
        end
        repeat (3) begin
            if (receive_data === 1'b1) rdp++;
            @(negedge PCLK);
        end
        per = t3 - t1;
    endtask

    logic [7:0] cap;
    int         low, rdp, per;

    initial begin
        PRESET = 1'b1; send_data = 1'b0; data_mosi = 8'h00;
        miso_val = 1'b0; loop_sel = 1'b0;
        spi_mode = 2'b00; spiswai = 1'b0; mstr = 1'b1;
        cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; spr = 3'd2; sppr = 3'd0;
        repeat (2) @(negedge PCLK);
        check("rst_ss", 12'(ss), 12'd1);
        check("rst_tip", 12'(tip), 12'd0);
        check("rst_mosi", 12'(mosi), 12'd0);
        check("rst_data_miso", 12'(data_miso), 12'h000);
        PRESET = 1'b0;

        // Divisor table
        sppr = 3'd0; spr = 3'd2; #1 check("baud_0_2", baud_rate_div, 12'd8);
        sppr = 3'd7; spr = 3'd7; #1 check("baud_7_7", baud_rate_div, 12'h800);
        sppr = 3'd0; spr = 3'd0; #1 check("baud_0_0", baud_rate_div, 12'd2);
        sppr = 3'd2; spr = 3'd1; #1 check("baud_2_1", baud_rate_div, 12'd12);
        sppr = 3'd0; spr = 3'd2;
        @(negedge PCLK);

        // Loopback, cpol=1 cpha=1 LSB first, 0xAA
        cpol = 1'b1; cpha = 1'b1; lsbfe = 1'b1; loop_sel = 1'b1;
        @(negedge PCLK);
        check("idle_sclk_high", 12'(sclk), 12'd1);
        start_xfer(8'hAA);
        run_frame(4, 1'b1, cap, low, rdp, per);
        check("aa_mosi_seq", 12'(cap), 12'h0AA);
        check("aa_ss_low", 12'(low), 12'd64);
        check("aa_rd_pulses", 12'(rdp), 12'd1);
        check("aa_data_miso", 12'(data_miso), 12'h0AA);
        check("aa_sclk_period", 12'(per), 12'd8);
        check("aa_sclk_idle", 12'(sclk), 12'd1);

        // cpol=0 cpha=0 MSB first, miso tied high, 0x3C
        cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; loop_sel = 1'b0; miso_val = 1'b1;
        @(negedge PCLK);
        start_xfer(8'h3C);
        run_frame(4, 1'b0, cap, low, rdp, per);
        check("3c_mosi_seq", 12'(cap), 12'h03C);
        check("3c_ss_low", 12'(low), 12'd64);
        check("3c_rd_pulses", 12'(rdp), 12'd1);
        check("3c_data_miso", 12'(data_miso), 12'h0FF);

        // Minimum divisor, loopback MSB first
        spr = 3'd0; sppr = 3'd0; cpol = 1'b1; cpha = 1'b0; lsbfe = 1'b0; loop_sel = 1'b1;
        @(negedge PCLK);
        start_xfer(8'hB4);
        run_frame(1, 1'b0, cap, low, rdp, per);
        check("b4_mosi_seq", 12'(cap), 12'h02D);
        check("b4_ss_low", 12'(low), 12'd16);
        check("b4_data_miso", 12'(data_miso), 12'h0B4);
        check("b4_sclk_period", 12'(per), 12'd2);

        // Wait mode with spiswai=0 still transfers; divisor 12
        spi_mode = 2'b01; spr = 3'd1; sppr = 3'd2; cpol = 1'b0; cpha = 1'b1; lsbfe = 1'b1;
        @(negedge PCLK);
        start_xfer(8'h1E);
        run_frame(6, 1'b1, cap, low, rdp, per);
        check("1e_mosi_seq", 12'(cap), 12'h01E);
        check("1e_ss_low", 12'(low), 12'd96);
        check("1e_rd_pulses", 12'(rdp), 12'd1);
        check("1e_data_miso", 12'(data_miso), 12'h01E);

        // Starts blocked by spiswai, stop mode and slave mode
        spiswai = 1'b1;
        start_xfer(8'h77);
        repeat (3) @(negedge PCLK);
        check("blk_swai_ss", 12'(ss), 12'd1);
        spiswai = 1'b0; spi_mode = 2'b11;
        start_xfer(8'h77);
        repeat (3) @(negedge PCLK);
        check("blk_stop_ss", 12'(ss), 12'd1);
        spi_mode = 2'b00; mstr = 1'b0;
        start_xfer(8'h77);
        repeat (3) @(negedge PCLK);
        check("blk_slave_ss", 12'(ss), 12'd1);
        mstr = 1'b1;

        // Abort after sclk edge 5, with an ignored mid-frame send and a coincident send
        spr = 3'd2; sppr = 3'd0; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
        loop_sel = 1'b0; miso_val = 1'b0;
        @(negedge PCLK);
        start_xfer(8'h5A);
        rdp = 0;
        for (int i = 0; i < 32; i++) begin
            if (receive_data === 1'b1) rdp++;
            if (i == 8) begin send_data = 1'b1; data_mosi = 8'hFF; end
            if (i == 9) begin
                send_data = 1'b0;
                check("abt_ignored_send", 12'(ss), 12'd0);
            end
            if (i == 20) begin
                check("abt_sclk_edge5", 12'(sclk), 12'd1);
                spi_mode = 2'b10; send_data = 1'b1;
            end
            if (i == 21) check("abt_ss_high", 12'(ss), 12'd1);
            if (i == 22) begin
                send_data = 1'b0;
                check("abt_no_restart", 12'(ss), 12'd1);
                check("abt_sclk_idle", 12'(sclk), 12'd0);
            end
            @(negedge PCLK);
        end
        check("abt_rd_pulses", 12'(rdp), 12'd0);
        check("abt_data_miso_kept", 12'(data_miso), 12'h01E);
        spi_mode = 2'b00;
        @(negedge PCLK);

        // Reset mid-frame, then a clean transfer
        cpol = 1'b1; cpha = 1'b1; lsbfe = 1'b0; loop_sel = 1'b1;
        @(negedge PCLK);
        start_xfer(8'h96);
        repeat (30) @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        check("mrst_ss", 12'(ss), 12'd1);
        check("mrst_tip", 12'(tip), 12'd0);
        check("mrst_sclk", 12'(sclk), 12'd1);
        check("mrst_mosi", 12'(mosi), 12'd0);
        check("mrst_data_miso", 12'(data_miso), 12'h000);
        PRESET = 1'b0;
        repeat (2) @(negedge PCLK);
        start_xfer(8'hD2);
        run_frame(4, 1'b1, cap, low, rdp, per);
        check("d2_mosi_seq", 12'(cap), 12'h04B);
        check("d2_ss_low", 12'(low), 12'd64);
        check("d2_rd_pulses", 12'(rdp), 12'd1);
        check("d2_data_miso", 12'(data_miso), 12'h0D2);

        repeat (2) @(negedge PCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_master_engine.md
# spi_master_engine

Clocked SPI master datapath behind the APB register slave: divides PCLK into SCLK, frames each 8-bit transfer with slave-select, and shifts a byte out on MOSI while capturing one from MISO. The register slave supplies mode, baud and format fields, pulses `send_data` with the TX byte, and reads the RX byte back when `receive_data` pulses.

## Interface
- No parameters. Frame fixed at 8 bits; divisor fixed at 12 bits.
- PCLK  in  1  system clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- send_data  in  1  one-cycle start request; TX byte taken from `data_mosi` on the same edge.
- data_mosi  in  8  byte to transmit.
- miso  in  1  serial input from slave.
- spi_mode  in  2  00 run, 01 wait, 10/11 stop.
- spiswai  in  1  in wait mode, 1 stops SCLK/transfers.
- mstr  in  1  1 = master; 0 blocks transfers.
- cpol, cpha  in  1 each  clock polarity / phase.
- lsbfe  in  1  1 = LSB first, 0 = MSB first (TX and RX).
- spr, sppr  in  3 each  baud exponent / prescaler.
- sclk  out  1  SPI clock.
- ss  out  1  active-low slave select.
- mosi  out  1  serial output.
- tip  out  1  transfer in progress (= ~ss).
- receive_data  out  1  one-cycle pulse at transfer completion.
- data_miso  out  8  last received byte, held until next completion.
- baud_rate_div  out  12  divisor = (sppr+1) * 2^(spr+1), combinational.

## Operation
- Enabled = mstr & (spi_mode==00 | (spi_mode==01 & ~spiswai)).
- Start: `send_data` high, enabled and ss=1 at edge T → shift reg loads `data_mosi`, bit counter cleared, ss=0 from T+1. `send_data` while ss=0 or disabled is ignored.
- Baud gen: half = baud_rate_div/2; counter runs 0..half-1 only while ss=0; sclk toggles when counter==half-1. While ss=1, sclk = cpol and counter = 0.
- 16 SCLK edges per frame, numbered 1..16. CPHA=0: first bit on mosi from T+1; sample miso on odd edges; next bit on even edges 2..14. CPHA=1: drive bit on odd edges; sample on even edges.
- Bit order by lsbfe; received bits assembled in the same order (lsbfe=1: first sampled bit → bit 0).
- After edge 16: ss=1, sclk back to cpol, `receive_data` pulses one cycle, `data_miso` updated the same edge.
- Abort: leaving enabled state mid-frame → ss=1, sclk=cpol next edge, no `receive_data`, data_miso unchanged.
- Stages 1-3 (baud/flags, ss/tip control, shift register) may be separate submodules; this block's ports are the contract.

## Timing
- Edge k of sclk at T+1+k*half; frame length 8*baud_rate_div cycles; ss rises and receive_data pulses at T+1+8*baud_rate_div.
- Min divisor 2 (half=1); max 2048 (12'h800), no overflow.
- Reset (any time, including mid-frame): next edge ss=1, tip=0, sclk=cpol, mosi=0, receive_data=0, data_miso=8'h00, counters 0.
- send_data coincident with abort condition: abort wins, no start.
- cpol/cpha/lsbfe/spr/sppr changes during a frame: undefined; register slave must hold them.

## Configuration
- SPI_LOOPBACK_EN: if defined, serial input is internally tied to mosi and the `miso` port is ignored; if undefined, `miso` is sampled normally.

## Test plan
- sppr=0, spr=2 → baud_rate_div=8; sppr=7, spr=7 → 12'h800; sclk period 8 cycles for the first.
- Loopback, cpol=1, cpha=1, lsbfe=1, BR=8, send 0xAA → mosi 0,1,0,1,0,1,0,1; ss low 64 cycles; receive_data one pulse; data_miso=0xAA; sclk idles high.
- cpol=0, cpha=0, lsbfe=0, miso tied 1, send 0x3C → mosi 0,0,1,1,1,1,0,0 MSB first; data_miso=0xFF.
- Mid-frame spi_mode→10 after edge 5 → ss=1 next cycle, no receive_data, data_miso keeps old value; second send_data during frame ignored.
- PRESET asserted mid-frame → all outputs at reset values next edge; new transfer after release completes normally.
